// File: rtl/multdiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The ALU opcodes are shared with the decoder that launches this unit.
package multdiv_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0]  ALU_OP_MUL = 5'd6;
  localparam logic [4:0]  ALU_OP_DIV = 5'd7;
  localparam logic [5:0]  MUL_ITERS  = 6'd16;
  localparam logic [5:0]  DIV_ITERS  = 6'd32;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Magnitude of a two's-complement word; INT_MIN maps to 2^31 as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Operand/control/result bundle between execute-stage issue logic and multdiv_unit.
// state is a read-only debug view of the unit's FSM.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  import multdiv_unit_pkg::*;

  logic [WIDTH-1:0] operandA;
  logic [WIDTH-1:0] operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  state_t           state;

  // Handshake: a one-cycle ctrl_MULT/ctrl_DIV pulse starts an operation (aborting
  // any in flight); data_resultRDY pulses for exactly one cycle when data_result
  // and data_exception become valid. There is no back-pressure; busy stalls issue.
  modport master (
    output operandA, operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy, state
  );

  modport slave (
    input  operandA, operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy, state
  );

endinterface

// File: rtl/multdiv_unit_nr_div_step.sv
// One non-restoring division step on magnitudes: shift the next dividend bit in
// from the quotient register and add or subtract the divisor by remainder sign.
module multdiv_unit_nr_div_step (
  input  logic [32:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] divisor,
  output logic [32:0] rem_next,
  output logic [31:0] quo_next
);

  logic [32:0] shifted;
  logic [32:0] sum;

  // The true result always lies in [-divisor, divisor), so modulo-2^33
  // arithmetic is exact even though 2*rem can momentarily exceed 33 bits.
  always_comb begin
    shifted = {rem[31:0], quo[31]};
    if (rem[32]) begin
      sum = shifted + {1'b0, divisor};
    end else begin
      sum = shifted - {1'b0, divisor};
    end
    rem_next = sum;
    quo_next = {quo[30:0], ~sum[32]};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (non-restoring) unit.
// Multiply takes 17 cycles, divide 33 (1 for a zero divisor); a new start aborts.
module multdiv_unit
  import multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  multdiv_unit_if.slave  bus
);

  state_t           state;
  logic [5:0]       count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic             extra;
  logic [32:0]      rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             div_zero;
  logic [WIDTH-1:0] result_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  logic             start;
  logic [33:0]      m_ext;
  logic [33:0]      addend;
  logic [33:0]      booth_sum;
  logic             mul_ovf;
  logic [32:0]      rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] q_signed;
  logic             div_ovf;

  assign start = bus.ctrl_MULT | bus.ctrl_DIV;

  // Booth digit from {mplier[1:0], extra}; the accumulator is widened by two
  // bits so adding +/-2M cannot overflow before the arithmetic shift.
  always_comb begin
    m_ext = {{2{mcand[WIDTH-1]}}, mcand};
    case ({mplier[1:0], extra})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    booth_sum = {{2{acc[WIDTH-1]}}, acc} + addend;
  end

  // Signed overflow when the upper 33 product bits are not a pure sign extension.
  assign mul_ovf = ~((&{acc, mplier[WIDTH-1]}) | ~(|{acc, mplier[WIDTH-1]}));

  multdiv_unit_nr_div_step u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Only a positive magnitude quotient of 2^31 (INT_MIN / -1) is unrepresentable.
  assign q_signed = neg_q ? (~quo + 32'd1) : quo;
  assign div_ovf  = quo[WIDTH-1] & ~neg_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      mcand    <= '0;
      acc      <= '0;
      mplier   <= '0;
      extra    <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      div_zero <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (start) begin
        count    <= '0;
        busy_q   <= 1'b1;
        mcand    <= bus.operandA;
        acc      <= '0;
        mplier   <= bus.operandB;
        extra    <= 1'b0;
        rem      <= '0;
        quo      <= abs32(bus.operandA);
        dvs      <= abs32(bus.operandB);
        neg_q    <= bus.operandA[WIDTH-1] ^ bus.operandB[WIDTH-1];
        div_zero <= (bus.operandB == '0);
        state    <= bus.ctrl_MULT ? ST_MUL : ST_DIV;
      end else begin
        case (state)
          ST_MUL: begin
            if (count == MUL_ITERS) begin
              state    <= ST_DONE;
              result_q <= mplier;
              exc_q    <= mul_ovf;
              rdy_q    <= 1'b1;
            end else begin
              acc    <= booth_sum[33:2];
              mplier <= {booth_sum[1:0], mplier[WIDTH-1:2]};
              extra  <= mplier[1];
              count  <= count + 6'd1;
            end
          end
          ST_DIV: begin
            if (div_zero) begin
              state    <= ST_DONE;
              result_q <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
            end else if (count == DIV_ITERS) begin
              state    <= ST_DONE;
              result_q <= q_signed;
              exc_q    <= div_ovf;
              rdy_q    <= 1'b1;
            end else begin
              rem   <= rem_next;
              quo   <= quo_next;
              count <= count + 6'd1;
            end
          end
          ST_DONE: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
  assign bus.state          = state;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: cycle-level reference model plus directed literal cases
// and randomized operations with occasional aborts.
module tb_multdiv_unit;
  import multdiv_unit_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mon_on = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  multdiv_unit_if #(.WIDTH(32)) bus ();

  multdiv_unit #(.WIDTH(32)) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] exp_res(input logic [31:0] a, input logic [31:0] b, input logic mul);
    longint p;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p[31:0];
    end
    if (b == 32'd0) return 32'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    p = longint'($signed(a)) / longint'($signed(b));
    return p[31:0];
  endfunction

  function automatic logic exp_exc(input logic [31:0] a, input logic [31:0] b, input logic mul);
    longint p;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p != longint'($signed(p[31:0]));
    end
    if (b == 32'd0) return 1'b1;
    return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic int exp_lat(input logic [31:0] b, input logic mul);
    if (mul) return 17;
    if (b == 32'd0) return 1;
    return 33;
  endfunction

  // ---------------- cycle-level model ----------------
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic        m_mul = 1'b0, m_exc = 1'b0, m_rdy = 1'b0, m_busy = 1'b0, m_active = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_res <= '0; m_exc <= 1'b0; m_rdy <= 1'b0; m_busy <= 1'b0;
      m_active <= 1'b0; m_left <= 0;
    end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
      m_a      <= bus.operandA;
      m_b      <= bus.operandB;
      m_mul    <= bus.ctrl_MULT;
      m_left   <= exp_lat(bus.operandB, bus.ctrl_MULT);
      m_active <= 1'b1;
      m_busy   <= 1'b1;
      m_rdy    <= 1'b0;
    end else if (m_active) begin
      if (m_left == 1) begin
        m_active <= 1'b0;
        m_rdy    <= 1'b1;
        m_res    <= exp_res(m_a, m_b, m_mul);
        m_exc    <= exp_exc(m_a, m_b, m_mul);
      end else begin
        m_left <= m_left - 1;
      end
    end else begin
      m_rdy  <= 1'b0;
      m_busy <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      chk("mon_rdy",    {31'd0, bus.data_resultRDY}, {31'd0, m_rdy});
      chk("mon_busy",   {31'd0, bus.busy},           {31'd0, m_busy});
      chk("mon_result", bus.data_result,             m_res);
      chk("mon_exc",    {31'd0, bus.data_exception}, {31'd0, m_exc});
    end
  end

  // ---------------- driver tasks (called at posedge+2) ----------------
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic mul, input logic div);
    bus.operandA  = a;
    bus.operandB  = b;
    bus.ctrl_MULT = mul;
    bus.ctrl_DIV  = div;
    @(posedge clk);
    #2;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    bus.operandA  = $urandom;
    bus.operandB  = $urandom;
  endtask

  task automatic wait_rdy(output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.data_resultRDY) seen = 1'b1;
      else lat++;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_rdy: no data_resultRDY within 80 cycles, expected a pulse");
      lat = -1;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic mul, input logic div,
                           input logic [31:0] er, input logic ee, input int el);
    int lat;
    start_op(a, b, mul, div);
    wait_rdy(lat);
    chk({name, "_lat"}, 32'(lat), 32'(el));
    chk({name, "_res"}, bus.data_result, er);
    chk({name, "_exc"}, {31'd0, bus.data_exception}, {31'd0, ee});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int rdy_seen;
    logic [31:0] a, b;
    logic mul;
    bus.operandA = '0; bus.operandB = '0;
    bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    mon_on  = 1'b1;
    @(negedge clk);
    chk("reset_result", bus.data_result, 32'd0);
    chk("reset_exc",  {31'd0, bus.data_exception}, 32'd0);
    chk("reset_rdy",  {31'd0, bus.data_resultRDY}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #2;

    run_check("mul_7x-6",   32'd7, 32'hFFFF_FFFA, 1, 0, 32'hFFFF_FFD6, 0, 17);
    run_check("mul_ovf",    32'h0001_0000, 32'h0001_0000, 1, 0, 32'd0, 1, 17);
    run_check("mul_max",    32'h7FFF_FFFF, 32'd1, 1, 0, 32'h7FFF_FFFF, 0, 17);
    run_check("div_-100/7", 32'hFFFF_FF9C, 32'd7, 0, 1, 32'hFFFF_FFF2, 0, 33);
    run_check("div_ovf",    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000, 1, 33);

    // Divide by zero; operandB changing after the start edge must be ignored.
    start_op(32'd5, 32'd0, 0, 1);
    bus.operandB = 32'd3;
    wait_rdy(lat);
    chk("div0_lat", 32'(lat), 32'd1);
    chk("div0_res", bus.data_result, 32'd0);
    chk("div0_exc", {31'd0, bus.data_exception}, 32'd1);

    // Abort a multiply at edge 5 with a divide.
    start_op(32'd3, 32'd4, 1, 0);
    repeat (4) @(posedge clk);
    #2;
    start_op(32'd20, 32'd3, 0, 1);
    wait_rdy(lat);
    chk("abort_lat", 32'(lat), 32'd33);
    chk("abort_res", bus.data_result, 32'd6);
    chk("abort_exc", {31'd0, bus.data_exception}, 32'd0);

    run_check("both_9x3", 32'd9, 32'd3, 1, 1, 32'd27, 0, 17);

    // Reset mid-divide: outputs clear at once and no completion follows.
    start_op(32'd100, 32'd7, 0, 1);
    repeat (9) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_result", bus.data_result, 32'd0);
    chk("rst_exc",  {31'd0, bus.data_exception}, 32'd0);
    chk("rst_rdy",  {31'd0, bus.data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    rdy_seen = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus.data_resultRDY) rdy_seen++;
    end
    chk("rst_no_rdy", 32'(rdy_seen), 32'd0);
    @(posedge clk);
    #2;
    run_check("post_rst_2x2", 32'd2, 32'd2, 1, 0, 32'd4, 0, 17);

    // Randomized operations, some aborted by a second start.
    for (int n = 0; n < 40; n++) begin
      a = pick();
      b = pick();
      mul = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        start_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'b1);
        repeat ($urandom_range(0, 19)) @(posedge clk);
        #2;
      end
      start_op(a, b, mul, ~mul);
      wait_rdy(lat);
      chk("rand_lat", 32'(lat), 32'(exp_lat(b, mul)));
      chk("rand_res", bus.data_result, exp_res(a, b, mul));
      chk("rand_exc", {31'd0, bus.data_exception}, {31'd0, exp_exc(a, b, mul)});
    end

    repeat (3) @(posedge clk);
    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, directly downstream of the instruction decoder.
- Launched by a one-cycle pulse derived from the decoder's mul/div flags (ALU opcode 0, alu_op 6/7).
- Returns a result plus an exception flag with a one-cycle ready pulse. Pipeline stall logic holds on busy.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported and verified.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- operandA  input  WIDTH  multiplicand / dividend (signed), sampled only on a start edge
- operandB  input  WIDTH  multiplier / divisor (signed), sampled only on a start edge
- ctrl_MULT  input  1  start-multiply pulse
- ctrl_DIV  input  1  start-divide pulse
- data_result  output  WIDTH  result, held until next completion
- data_exception  output  1  exception flag, valid with data_result
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset (async, reset_n=0): state IDLE, data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0. Reset mid-operation abandons it; no RDY is ever produced for it.
- States: IDLE, MUL, DIV, DONE.
  - Start edge = rising edge with ctrl_MULT|ctrl_DIV=1; call it edge 0.
  - Operands are latched at edge 0. Later operand changes are ignored.
- MUL uses radix-4 Booth, 16 iterations, on a 65-bit {acc, mplier, extra} register.
  - Edges 1..16 perform one step each. Edge 17 enters DONE.
  - data_resultRDY is high in the cycle after edge 17 (17-cycle latency).
  - data_result = low 32 bits of the product.
  - data_exception = 1 iff the 64-bit product's upper 33 bits are not all equal (signed overflow).
- DIV uses non-restoring division on magnitudes, 32 iterations (edges 1..32), sign fix-up at edge 33; RDY follows edge 33.
  - Quotient truncates toward zero; the remainder is discarded.
  - Divisor 0: DONE at edge 1, result 0, exception 1, RDY after edge 1.
  - 0x80000000 / 0xFFFFFFFF: full 33-cycle latency, result 0x80000000, exception 1.
- DONE → IDLE on the next edge. data_resultRDY is asserted only in DONE. data_result and data_exception update on entry to DONE and hold afterwards.
- busy = 1 in MUL and DIV, and in DONE. busy = 0 in IDLE.
- A start while busy (including in DONE) aborts the current operation and restarts from edge 0 with the new operands. No RDY is produced for the aborted operation.
- ctrl_MULT and ctrl_DIV both high: treated as MULT.
- The iteration counter is 6 bits and resets on every start. No wrap-around is possible within an operation.

Decomposition:
- Shared package holds:
  - state enum (IDLE/MUL/DIV/DONE);
  - ALU_OP_MUL=5'd6, ALU_OP_DIV=5'd7 (shared with the decoder);
  - MUL_ITERS=16, DIV_ITERS=32;
  - INT_MIN constant.
- One combinational sub-module, nr_div_step: takes partial remainder, quotient and divisor magnitude; outputs the next remainder and quotient. Booth recoding stays inline in multdiv_unit.

Test Plan:
- MULT A=7, B=-6 (0xFFFFFFFA) → RDY high only in the cycle after edge 17; result 0xFFFFFFD6, exception 0; busy high edges 0..17.
- MULT A=0x00010000, B=0x00010000 → after 17 cycles result 0x00000000, exception 1. MULT 0x7FFFFFFF × 1 → 0x7FFFFFFF, exception 0.
- DIV A=-100, B=7 → RDY after edge 33, result 0xFFFFFFF2 (-14), exception 0. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, exception 1.
- DIV A=5, B=0 → RDY after edge 1, result 0, exception 1; operandB changed to 3 at edge 1 has no effect.
- MULT 3×4 at edge 0, then DIV 20/3 at edge 5 → no RDY at cycle 17; RDY after edge 38 with result 6. Simultaneous ctrl_MULT and ctrl_DIV with 9, 3 → result 27 after 17 cycles.
- DIV started, reset_n pulsed low at cycle 10 → all outputs 0 immediately. No RDY through cycle 40. A subsequent MULT 2×2 → 4 after 17 cycles.
